attack_engine: RTL

- Frame-paced melee attack controller with hitbox/sprite-address generator for the player's directional slash.
- Sequences each attack through ACTIVE and COOLDOWN phases, with a configurable number of animation forms.
- Latches origin and direction at attack start.
- Feeds is_obj/obj_addr to the color mapper and sprite ROM, and obj_on/obj position to enemy collision logic.

---
 rtl/attack_pkg.sv | 51 +++++
 rtl/attack_hitbox.sv | 83 ++++++++
 rtl/attack_engine.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/attack_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | attack_pkg                                                               |
// | Shared types and origin offsets for the melee attack engine.             |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package attack_pkg;

   typedef enum logic [1:0] {
      DIR_DOWN  = 2'd0,
      DIR_LEFT  = 2'd1,
      DIR_UP    = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ATK_IDLE     = 2'd0,
      ATK_ACTIVE   = 2'd1,
      ATK_COOLDOWN = 2'd2
   } atk_state_t;

   // Hitbox origin relative to the player sprite top-left, per facing.
   localparam int OFF_DOWN_X  = -2;
   localparam int OFF_DOWN_Y  = 20;
   localparam int OFF_LEFT_X  = 0;
   localparam int OFF_LEFT_Y  = 2;
   localparam int OFF_UP_X    = 1;
   localparam int OFF_UP_Y    = 0;
   localparam int OFF_RIGHT_X = 18;
   localparam int OFF_RIGHT_Y = 2;

   function automatic int origin_off_x(input dir_t d);
      case (d)
         DIR_DOWN: return OFF_DOWN_X;
         DIR_LEFT: return OFF_LEFT_X;
         DIR_UP:   return OFF_UP_X;
         default:  return OFF_RIGHT_X;
      endcase
   endfunction

   function automatic int origin_off_y(input dir_t d);
      case (d)
         DIR_DOWN: return OFF_DOWN_Y;
         DIR_LEFT: return OFF_LEFT_Y;
         DIR_UP:   return OFF_UP_Y;
         default:  return OFF_RIGHT_Y;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/attack_hitbox.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | attack_hitbox                                                            |
// | Combinational in-box test and sprite ROM address for the slash hitbox.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module attack_hitbox
   import attack_pkg::*;
#(
   parameter int COORD_W = 9,
   parameter int SHORT   = 16,
   parameter int LONG    = 80,
   parameter int ADDR_W  = 10
) (
   input  logic [COORD_W-1:0] i_ox,
   input  logic [COORD_W-1:0] i_oy,
   input  dir_t               i_dir,
   input  logic [ADDR_W-1:0]  i_form,
   input  logic [COORD_W-1:0] i_px,
   input  logic [COORD_W-1:0] i_py,
   output logic               o_in_box,
   output logic [ADDR_W-1:0]  o_addr
);

   // Two extra bits: one for sign, one so origin +/- LONG never overflows.
   localparam int SW     = COORD_W + 2;
   localparam int SH_LOG = $clog2(SHORT);

   localparam logic signed [SW-1:0] C_SHORT = SW'(SHORT);
   localparam logic signed [SW-1:0] C_LONG  = SW'(LONG);
   localparam logic signed [SW-1:0] C_ONE   = SW'(1);

   logic signed [SW-1:0] w_ox, w_oy, w_px, w_py;
   logic signed [SW-1:0] w_x_lo, w_x_hi, w_y_lo, w_y_hi;
   logic signed [SW-1:0] w_dx, w_dy;

   assign w_ox = $signed({2'b00, i_ox});
   assign w_oy = $signed({2'b00, i_oy});
   assign w_px = $signed({2'b00, i_px});
   assign w_py = $signed({2'b00, i_py});

   // Box bounds and 0-based distances from the blade root, per facing.
   always_comb begin
      w_x_lo = w_ox;
      w_x_hi = w_ox + C_LONG;
      w_y_lo = w_oy;
      w_y_hi = w_oy + C_SHORT;
      w_dx   = w_px - w_ox;
      w_dy   = w_py - w_oy;
      case (i_dir)
         DIR_DOWN: begin
            w_x_hi = w_ox + C_SHORT;
            w_y_hi = w_oy + C_LONG;
         end
         DIR_LEFT: begin
            w_x_lo = w_ox - C_LONG;
            w_x_hi = w_ox;
            w_dx   = w_ox - C_ONE - w_px;
         end
         DIR_UP: begin
            w_x_hi = w_ox + C_SHORT;
            w_y_lo = w_oy - C_LONG;
            w_y_hi = w_oy;
            w_dy   = w_oy - C_ONE - w_py;
         end
         default: begin
         end
      endcase
   end

   // Pixels are never negative or past the raster, so the signed compare
   // clips the box at the screen edges instead of wrapping it.
   // Inside the box the short-axis distance is already below SHORT, so
   // taking both distances mod SHORT gives the tile address for every facing.
   always_comb begin
      o_in_box = (w_px >= w_x_lo) && (w_px < w_x_hi) &&
                 (w_py >= w_y_lo) && (w_py < w_y_hi);
      o_addr   = (i_form << (2 * SH_LOG)) +
                 ADDR_W'({w_dy[SH_LOG-1:0], w_dx[SH_LOG-1:0]});
   end

endmodule
`default_nettype wire

// File: rtl/attack_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | attack_engine                                                            |
// | Frame-paced melee attack sequencer with hitbox / sprite address output.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module attack_engine
   import attack_pkg::*;
#(
   parameter int         COORD_W         = 9,
   parameter int         SHORT           = 16,
   parameter int         LONG            = 80,
   parameter int         N_FORMS         = 2,
   parameter int         FORM_FRAMES     = 2,
   parameter int         ACTIVE_FRAMES   = 4,
   parameter int         COOLDOWN_FRAMES = 4,
   parameter logic [7:0] ATTACK_KEY      = 8'd44,
   parameter bit         AUTO_REPEAT     = 1'b0,
   parameter int         ADDR_W          = 10
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               frame_tick,
   input  logic [7:0]         keycode,
   input  logic [COORD_W-1:0] player_x,
   input  logic [COORD_W-1:0] player_y,
   input  logic [1:0]         player_dir,
   input  logic [COORD_W-1:0] pixel_x,
   input  logic [COORD_W-1:0] pixel_y,
   output logic               is_obj,
   output logic [ADDR_W-1:0]  obj_addr,
   output logic               obj_on,
   output logic [COORD_W-1:0] obj_x,
   output logic [COORD_W-1:0] obj_y,
   output logic [1:0]         obj_dir,
   output logic               attack_start,
   output logic               busy
);

   localparam int CNT_MAX = (ACTIVE_FRAMES > COOLDOWN_FRAMES) ? ACTIVE_FRAMES : COOLDOWN_FRAMES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int FORM_W  = (N_FORMS > 1) ? $clog2(N_FORMS) : 1;
   localparam int FF_W    = (FORM_FRAMES > 1) ? $clog2(FORM_FRAMES) : 1;

   localparam logic [CNT_W-1:0]  C_ACT_LOAD  = CNT_W'(ACTIVE_FRAMES - 1);
   localparam logic [CNT_W-1:0]  C_COOL_LOAD = CNT_W'((COOLDOWN_FRAMES > 0) ? COOLDOWN_FRAMES - 1 : 0);
   localparam logic [FORM_W-1:0] C_FORM_LAST = FORM_W'(N_FORMS - 1);
   localparam logic [FF_W-1:0]   C_FF_LAST   = FF_W'(FORM_FRAMES - 1);

   atk_state_t         r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [FORM_W-1:0]  r_form;
   logic [FF_W-1:0]    r_ff;
   logic               r_armed;
   logic [COORD_W-1:0] r_obj_x, r_obj_y;
   dir_t               r_obj_dir;
   logic               r_attack_start, r_obj_on, r_busy;

   logic               w_key_hit, w_cnt_zero, w_start;
   logic               w_in_box, w_is_obj;
   logic [ADDR_W-1:0]  w_box_addr, w_obj_addr;
   dir_t               w_pdir;

   assign w_key_hit  = (keycode == ATTACK_KEY);
   assign w_cnt_zero = (r_cnt == '0);
   assign w_pdir     = dir_t'(player_dir);

   // FSM state register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) r_state <= ATK_IDLE;
      else       r_state <= w_state_nxt;
   end

   // FSM next state: transitions only on frame ticks.
   always_comb begin
      w_state_nxt = r_state;
      if (frame_tick) begin
         case (r_state)
            ATK_IDLE: begin
               if (w_key_hit && r_armed) w_state_nxt = ATK_ACTIVE;
            end
            ATK_ACTIVE: begin
               if (w_cnt_zero) begin
                  if (COOLDOWN_FRAMES == 0) w_state_nxt = ATK_IDLE;
                  else                      w_state_nxt = ATK_COOLDOWN;
               end
            end
            ATK_COOLDOWN: begin
               if (w_cnt_zero) w_state_nxt = ATK_IDLE;
            end
            default: w_state_nxt = ATK_IDLE;
         endcase
      end
   end

   // FSM outputs: attack trigger strobe and the gated hitbox pixel outputs.
   always_comb begin
      w_start    = frame_tick && (r_state == ATK_IDLE) && w_key_hit && r_armed;
      w_is_obj   = w_in_box && (r_state == ATK_ACTIVE);
      w_obj_addr = w_is_obj ? w_box_addr : '0;
   end

   // Phase counter, animation form stepping and origin/direction latch.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_cnt     <= '0;
         r_form    <= '0;
         r_ff      <= '0;
         r_obj_x   <= '0;
         r_obj_y   <= '0;
         r_obj_dir <= DIR_DOWN;
      end else if (frame_tick) begin
         if (w_start) begin
            r_cnt     <= C_ACT_LOAD;
            r_form    <= '0;
            r_ff      <= '0;
            r_obj_dir <= w_pdir;
            r_obj_x   <= player_x + COORD_W'(origin_off_x(w_pdir));
            r_obj_y   <= player_y + COORD_W'(origin_off_y(w_pdir));
         end else if (r_state == ATK_ACTIVE) begin
            r_cnt <= w_cnt_zero ? C_COOL_LOAD : r_cnt - 1'b1;
            if (r_ff == C_FF_LAST) begin
               r_ff   <= '0;
               r_form <= (r_form == C_FORM_LAST) ? '0 : r_form + 1'b1;
            end else begin
               r_ff <= r_ff + 1'b1;
            end
         end else if (r_state == ATK_COOLDOWN) begin
            r_cnt <= w_cnt_zero ? '0 : r_cnt - 1'b1;
         end
      end
   end

   // Arming: without auto-repeat the key must be seen released before re-firing.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_armed <= 1'b1;
      end else if (AUTO_REPEAT) begin
         r_armed <= 1'b1;
      end else if (frame_tick) begin
         if (w_start)         r_armed <= 1'b0;
         else if (!w_key_hit) r_armed <= 1'b1;
      end
   end

   // Registered status: start strobe and state flags lagging the state by one Clk.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_attack_start <= 1'b0;
         r_obj_on       <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_attack_start <= w_start;
         r_obj_on       <= (r_state == ATK_ACTIVE);
         r_busy         <= (r_state != ATK_IDLE);
      end
   end

   attack_hitbox #(
      .COORD_W (COORD_W),
      .SHORT   (SHORT),
      .LONG    (LONG),
      .ADDR_W  (ADDR_W)
   ) u_hitbox (
      .i_ox     (r_obj_x),
      .i_oy     (r_obj_y),
      .i_dir    (r_obj_dir),
      .i_form   (ADDR_W'(r_form)),
      .i_px     (pixel_x),
      .i_py     (pixel_y),
      .o_in_box (w_in_box),
      .o_addr   (w_box_addr)
   );

   assign is_obj       = w_is_obj;
   assign obj_addr     = w_obj_addr;
   assign obj_on       = r_obj_on;
   assign obj_x        = r_obj_x;
   assign obj_y        = r_obj_y;
   assign obj_dir      = r_obj_dir;
   assign attack_start = r_attack_start;
   assign busy         = r_busy;

endmodule
`default_nettype wire
